ni_pkt_enc: RTL and testbench
=============================

// Module: ni_pkt_enc
// PURPOSE
//  Network-interface packetizer: the injection-side counterpart of the router's routing
//  decoder (dec_rt). Turns a local send request plus a payload stream into 66-bit flits
//  (head/body/tail) carrying a unicast node ID or a 56-bit multicast destination bitmap.
//  Drives the router local input port under credit-based flow control (no VCs).
// PARAMETERS
//  X         0   this node's column
//  Y         0   this node's row
//  MESH_X    8   mesh columns; node ID = Y*MESH_X+X (56 nodes max, 8x7)
//  BUF_DEPTH 4   router local-port input buffer depth = initial credit count (1..15)
//  MAXLEN    8   max payload flits per packet (1..15)
// PORTS
//  clk          in   1   clock, rising edge
//  rstn         in   1   asynchronous active-low reset
//  req_valid    in   1   send request valid
//  req_ready    out  1   request accepted when req_valid&req_ready at a rising edge
//  req_um_type  in   1   0 unicast, 1 multicast
//  req_dst      in   11  unicast destination node ID
//  req_mdst     in   56  multicast bitmap, bit i = node i
//  req_len      in   4   payload flit count, 0..MAXLEN
//  pay_valid    in   1   payload word valid
//  pay_ready    out  1   payload word consumed when pay_valid&pay_ready at a rising edge
//  pay_data     in   64  payload word
//  credit_in    in   1   1-cycle pulse: router freed one local-port buffer slot
//  flit_valid   out  1   flit_out valid this cycle (push, no backpressure)
//  flit_out     out  66  flit
//  req_err      out  1   1-cycle pulse: request dropped (empty target set, or len>MAXLEN)
// BEHAVIOUR
//  Flit format: [65:64] type 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL; [63] UM_TYPE.
//   Unicast head: [62:52] dst ID, [51:41] src ID, [40:0] 0. Multicast head: [62:7]
//   bitmap, [6:0] 0. Body/tail: [63:0] payload word.
//  Reset: state IDLE, credit=BUF_DEPTH, flit_valid=0, flit_out=0, req_err=0,
//   req_ready=0 while rstn low; all in-flight request/payload state discarded.
//  FSM IDLE -> HEAD -> PAY -> IDLE.
//   IDLE: req_ready=1. On accept, latch the request. Multicast: clear own bit in bitmap.
//    If the resulting bitmap is 0, unicast dst == own ID, or req_len>MAXLEN: pulse req_err
//    next cycle, stay IDLE. Otherwise go to HEAD.
//   HEAD: req_ready=0. When credit>0, register the head flit (type 11 if len==0 -> IDLE,
//    else type 00 -> PAY, remaining=len).
//   PAY: pay_ready = (credit>0). On a payload handshake, register BODY (remaining>1) or
//    TAIL (remaining==1); on TAIL go to IDLE. A payload gap gives no flit (flit_valid=0).
//  Latency: request accepted at edge N -> head on flit_out after edge N+1 (credit
//   permitting). One flit max per cycle; back-to-back packets leave a 1-cycle IDLE bubble.
//  flit_out is registered; flit_valid high for exactly one cycle per flit and never high
//   when credit was 0 at the issuing edge.
//  Credit counter 4 bits: -1 per flit sent, +1 per credit_in. Both in the same cycle:
//   unchanged. Credit never exceeds BUF_DEPTH; credit_in at BUF_DEPTH is ignored and
//   flagged by an assertion.
//  pay_data is sampled only on a handshake; pay_valid outside PAY is ignored.
// TESTING
//  Node (0,0), unicast dst 5, len 0, credit 4 -> one flit {11,0,11'd5,11'd0,41'b0}; credit 3.
//  Multicast mdst=0x111 at node 0, len 2, words A,B -> HEAD bitmap 0x110, BODY A, TAIL B, req_err=0.
//  Multicast mdst=0x1 at node 0 -> req_err pulse, no flits, credit unchanged.
//  BUF_DEPTH 2, len 3, no credit_in -> HEAD + BODY only, then stall. One credit_in pulse
//   -> one more BODY. Second credit_in -> TAIL. flit_valid never asserted at credit 0.
//  credit_in coincident with a flit send at credit 1 -> credit stays 1, next flit not stalled.
//  rstn low mid-packet (after HEAD) -> outputs 0, credit = BUF_DEPTH, IDLE, req_ready
//   high after release.

Source files
------------

// File: rtl/ni_pkt_enc_if.sv
// ni_pkt_enc_if: request, payload, credit and flit signals of the NI packetizer.
`timescale 1ns/1ps
interface ni_pkt_enc_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_um_type;
    logic [10:0] req_dst;
    logic [55:0] req_mdst;
    logic [3:0]  req_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [63:0] pay_data;
    logic        credit_in;
    logic        flit_valid;
    logic [65:0] flit_out;
    logic        req_err;

    modport slave (
        input  req_valid, req_um_type, req_dst, req_mdst, req_len,
        input  pay_valid, pay_data, credit_in,
        output req_ready, pay_ready, flit_valid, flit_out, req_err
    );

    modport master (
        output req_valid, req_um_type, req_dst, req_mdst, req_len,
        output pay_valid, pay_data, credit_in,
        input  req_ready, pay_ready, flit_valid, flit_out, req_err
    );
endinterface

// File: rtl/ni_pkt_enc.sv
// ni_pkt_enc: NI injection packetizer, request + payload stream to
// head/body/tail flits under credit flow control toward the router local port.
`timescale 1ns/1ps
module ni_pkt_enc #(
    parameter int X         = 0,
    parameter int Y         = 0,
    parameter int MESH_X    = 8,
    parameter int BUF_DEPTH = 4,
    parameter int MAXLEN    = 8
) (
    input  logic        clk,
    input  logic        rstn,
    ni_pkt_enc_if.slave bus
);
    localparam logic [10:0] OWN   = 11'(Y * MESH_X + X);
    localparam logic [3:0]  DEPTH = 4'(BUF_DEPTH);
    localparam logic [3:0]  MAXL  = 4'(MAXLEN);

    typedef enum logic [1:0] {IDLE, HEAD, PAY} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_credit;
    logic [3:0]  r_len;
    logic [3:0]  r_rem;
    logic        r_um;
    logic [10:0] r_dst;
    logic [55:0] r_mdst;
    logic        r_flit_valid;
    logic [65:0] r_flit;
    logic        r_err;

    logic        w_has_cred;
    logic        w_accept;
    logic        w_bad;
    logic        w_pay_hs;
    logic        w_send;
    logic        w_latch;
    logic        w_cred_inc;
    logic [55:0] w_mask;
    logic [65:0] w_flit;

    assign w_has_cred = (r_credit != '0);
    assign w_accept   = bus.req_valid & bus.req_ready;
    assign w_mask     = bus.req_mdst & ~(56'd1 << OWN);
    assign w_bad      = (bus.req_len > MAXL) |
                        (bus.req_um_type ? (w_mask == '0)
                                         : (bus.req_dst == OWN));
    assign w_pay_hs   = bus.pay_valid & bus.pay_ready;
    // A credit returned while the counter is full is dropped unless a flit
    // leaves in the same cycle.
    assign w_cred_inc = bus.credit_in & (r_credit != DEPTH);

    assign bus.req_ready  = rstn & (r_state == IDLE);
    assign bus.pay_ready  = (r_state == PAY) & w_has_cred;
    assign bus.flit_valid = r_flit_valid;
    assign bus.flit_out   = r_flit;
    assign bus.req_err    = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_send  = 1'b0;
        w_latch = 1'b0;
        w_flit  = r_flit;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !w_bad) begin
                    w_latch = 1'b1;
                    w_next  = HEAD;
                end
            end
            HEAD: begin
                if (w_has_cred) begin
                    w_send = 1'b1;
                    w_flit[63:0] = r_um ? {1'b1, r_mdst, 7'd0}
                                        : {1'b0, r_dst, OWN, 41'd0};
                    w_flit[65:64] = (r_len == '0) ? 2'b11 : 2'b00;
                    w_next = (r_len == '0) ? IDLE : PAY;
                end
            end
            PAY: begin
                if (w_pay_hs) begin
                    w_send = 1'b1;
                    w_flit = {(r_rem == 4'd1) ? 2'b10 : 2'b01, bus.pay_data};
                    if (r_rem == 4'd1) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit     <= DEPTH;
            r_len        <= '0;
            r_rem        <= '0;
            r_um         <= 1'b0;
            r_dst        <= '0;
            r_mdst       <= '0;
            r_flit_valid <= 1'b0;
            r_flit       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err        <= w_accept & w_bad;
            r_flit_valid <= w_send;
            if (w_send) r_flit <= w_flit;
            if (w_latch) begin
                r_um   <= bus.req_um_type;
                r_dst  <= bus.req_dst;
                r_mdst <= w_mask;
                r_len  <= bus.req_len;
            end
            if (r_state == HEAD && w_has_cred) r_rem <= r_len;
            else if (r_state == PAY && w_pay_hs) r_rem <= r_rem - 4'd1;
            if (w_send && !bus.credit_in)     r_credit <= r_credit - 4'd1;
            else if (!w_send && w_cred_inc)   r_credit <= r_credit + 4'd1;
        end
    end

    a_credit_ovf: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.credit_in && !w_send && r_credit == DEPTH));
endmodule

// File: tb/tb_ni_pkt_enc.sv
// tb_ni_pkt_enc: scoreboard bench, one DUT at BUF_DEPTH 4 and one at 2.
`timescale 1ns/1ps
module tb_ni_pkt_enc;
    typedef logic [66:0] item_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    ni_pkt_enc_if b0();
    ni_pkt_enc_if b1();

    ni_pkt_enc u0 (.clk(clk), .rstn(rst0), .bus(b0.slave));
    ni_pkt_enc #(.BUF_DEPTH(2)) u1 (.clk(clk), .rstn(rst1), .bus(b1.slave));

    int    n_chk  = 0;
    int    n_fail = 0;
    item_t q0[$];
    item_t q1[$];
    int    cred0 = 4;
    int    cred1 = 2;
    int    cnt1  = 0;
    logic  cin0_s = 1'b0;
    logic  cin1_s = 1'b0;

    localparam item_t ERR = {1'b1, 66'd0};

    task automatic check(input string tag, input item_t got, input item_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic item_t hu(input logic [10:0] dst, input logic [3:0] len);
        return {1'b0, (len == 0) ? 2'b11 : 2'b00, 1'b0, dst, 11'd0, 41'd0};
    endfunction

    function automatic item_t hm(input logic [55:0] map, input logic [3:0] len);
        return {1'b0, (len == 0) ? 2'b11 : 2'b00, 1'b1, map, 7'd0};
    endfunction

    always @(posedge clk) begin
        cin0_s <= b0.credit_in;
        cin1_s <= b1.credit_in;
    end

    always @(negedge clk) begin
        item_t e;
        if (!rst0) cred0 = 4;
        else begin
            if (b0.flit_valid) begin
                check("cred0_pos", item_t'(cred0 > 0), 67'd1);
                e = (q0.size() > 0) ? q0.pop_front() : '1;
                check("flit0", {1'b0, b0.flit_out}, e);
            end
            if (b0.req_err) begin
                e = (q0.size() > 0) ? q0.pop_front() : '1;
                check("err0", {b0.req_err, 66'd0}, e);
            end
            cred0 = cred0 - (b0.flit_valid ? 1 : 0) + (cin0_s ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        item_t e;
        if (!rst1) cred1 = 2;
        else begin
            if (b1.flit_valid) begin
                cnt1++;
                check("cred1_pos", item_t'(cred1 > 0), 67'd1);
                e = (q1.size() > 0) ? q1.pop_front() : '1;
                check("flit1", {1'b0, b1.flit_out}, e);
            end
            if (b1.req_err) begin
                e = (q1.size() > 0) ? q1.pop_front() : '1;
                check("err1", {b1.req_err, 66'd0}, e);
            end
            cred1 = cred1 - (b1.flit_valid ? 1 : 0) + (cin1_s ? 1 : 0);
        end
    end

    task automatic set_req(input int s, input logic v, input logic um,
                           input logic [10:0] dst, input logic [55:0] mdst,
                           input logic [3:0] len);
        if (s == 0) begin
            b0.req_valid = v; b0.req_um_type = um; b0.req_dst = dst;
            b0.req_mdst = mdst; b0.req_len = len;
        end else begin
            b1.req_valid = v; b1.req_um_type = um; b1.req_dst = dst;
            b1.req_mdst = mdst; b1.req_len = len;
        end
    endtask

    task automatic set_pay(input int s, input logic v, input logic [63:0] d);
        if (s == 0) begin b0.pay_valid = v; b0.pay_data = d; end
        else        begin b1.pay_valid = v; b1.pay_data = d; end
    endtask

    task automatic set_cin(input int s, input logic v);
        if (s == 0) b0.credit_in = v;
        else        b1.credit_in = v;
    endtask

    task automatic push(input int s, input item_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pulse(input int s);
        set_cin(s, 1'b1);
        @(posedge clk); #1;
        set_cin(s, 1'b0);
    endtask

    task automatic req(input int s, input logic um, input logic [10:0] dst,
                       input logic [55:0] mdst, input logic [3:0] len,
                       input item_t exp);
        logic ok = 1'b0;
        set_req(s, 1'b1, um, dst, mdst, len);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? b0.req_ready : b1.req_ready;
            @(posedge clk); #1;
        end
        set_req(s, 1'b0, 1'b0, '0, '0, '0);
        if (ok) push(s, exp);
        else check("req_timeout", 67'd0, 67'd1);
    endtask

    task automatic pay(input int s, input logic [63:0] d, input logic last);
        logic ok = 1'b0;
        push(s, {1'b0, last ? 2'b10 : 2'b01, d});
        set_pay(s, 1'b1, d);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? b0.pay_ready : b1.pay_ready;
            @(posedge clk); #1;
        end
        set_pay(s, 1'b0, '0);
        if (!ok) check("pay_timeout", 67'd0, 67'd1);
    endtask

    task automatic drain(input int s);
        int n;
        for (int i = 0; i < 50; i++) begin
            n = (s == 0) ? q0.size() : q1.size();
            if (n == 0) break;
            @(negedge clk);
        end
        n = (s == 0) ? q0.size() : q1.size();
        check("drain", item_t'(n), 67'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_out(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, item_t'(b0.flit_valid), 67'd0);
        check({tag, "_flit"},  item_t'(b0.flit_out),   67'd0);
        check({tag, "_err"},   item_t'(b0.req_err),    67'd0);
        check({tag, "_rdy"},   item_t'(b0.req_ready),  67'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int pulses;
        rst0 = 1'b0;
        rst1 = 1'b0;
        for (int s = 0; s < 2; s++) begin
            set_req(s, 1'b0, 1'b0, '0, '0, '0);
            set_pay(s, 1'b0, '0);
            set_cin(s, 1'b0);
        end
        repeat (2) @(posedge clk);
        chk_reset_out("rst");
        @(posedge clk); #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", item_t'(b0.req_ready), 67'd1);
        @(posedge clk); #1;

        set_pay(0, 1'b1, 64'hDEAD_BEEF_0000_0001);
        repeat (3) @(posedge clk); #1;
        set_pay(0, 1'b0, '0);

        req(0, 1'b0, 11'd5, '0, 4'd0, hu(11'd5, 4'd0));
        drain(0);

        req(0, 1'b1, '0, 56'h111, 4'd2, hm(56'h110, 4'd2));
        pay(0, 64'hAAAA_0000_1111_2222, 1'b0);
        pay(0, 64'hBBBB_3333_4444_5555, 1'b1);
        drain(0);

        req(0, 1'b1, '0, 56'h1, 4'd0, ERR);
        req(0, 1'b0, 11'd0, '0, 4'd1, ERR);
        req(0, 1'b0, 11'd5, '0, 4'd9, ERR);
        drain(0);

        repeat (4) pulse(0);
        req(0, 1'b0, 11'd7, '0, 4'd2, hu(11'd7, 4'd2));
        repeat (3) @(posedge clk); #1;
        drain(0);
        rst0 = 1'b0;
        q0.delete();
        chk_reset_out("mid_rst");
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(negedge clk);
        check("rdy_after_mid_rst", item_t'(b0.req_ready), 67'd1);
        @(posedge clk); #1;

        req(0, 1'b0, 11'd9, '0, 4'd3, hu(11'd9, 4'd3));
        pay(0, 64'h1, 1'b0);
        pay(0, 64'h2, 1'b0);
        pay(0, 64'h3, 1'b1);
        drain(0);

        fork
            begin
                req(0, 1'b1, '0, 56'hFF00, 4'd8, hm(56'hFF00, 4'd8));
                for (int k = 0; k < 8; k++)
                    pay(0, 64'(k + 100), k == 7);
            end
            begin
                pulses = 0;
                for (int i = 0; i < 300 && pulses < 9; i++) begin
                    if (cred0 < 4) begin
                        pulse(0);
                        @(posedge clk); #1;
                        pulses++;
                    end else begin
                        @(posedge clk); #1;
                    end
                end
            end
        join
        drain(0);

        fork
            begin
                req(1, 1'b0, 11'd3, '0, 4'd3, hu(11'd3, 4'd3));
                pay(1, 64'hC, 1'b0);
                pay(1, 64'hD, 1'b0);
                pay(1, 64'hE, 1'b1);
            end
            begin
                for (int i = 0; i < 50 && cnt1 < 2; i++) @(posedge clk);
                repeat (8) @(posedge clk); #1;
                check("stall_2", item_t'(cnt1), 67'd2);
                pulse(1);
                repeat (5) @(posedge clk); #1;
                check("stall_3", item_t'(cnt1), 67'd3);
                pulse(1);
                repeat (5) @(posedge clk); #1;
                check("done_4", item_t'(cnt1), 67'd4);
            end
        join
        drain(1);

        pulse(1);
        req(1, 1'b0, 11'd4, '0, 4'd1, hu(11'd4, 4'd1));
        set_cin(1, 1'b1);
        @(posedge clk); #1;
        set_cin(1, 1'b0);
        pay(1, 64'hF, 1'b1);
        drain(1);

        req(1, 1'b0, 11'd6, '0, 4'd0, hu(11'd6, 4'd0));
        c = cnt1;
        repeat (6) @(posedge clk); #1;
        check("stall_head", item_t'(cnt1), item_t'(c));
        pulse(1);
        drain(1);
        check("head_after_cred", item_t'(cnt1), item_t'(c + 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
